// File: rtl/vga_timing_pkg.sv
// Shared raster timing types and default 640x480@60 timing constants.
// Frame counter feature macro: VGA_TIMING_FRAME_CNT_EN (used by vga_timing_core).
package vga_timing_pkg;

   typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} vga_phase_t;

   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FRONT  = 16;
   localparam int unsigned VGA_H_SYNC   = 96;
   localparam int unsigned VGA_H_BACK   = 48;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FRONT  = 10;
   localparam int unsigned VGA_V_SYNC   = 2;
   localparam int unsigned VGA_V_BACK   = 33;
   localparam bit          VGA_SYNC_NEG = 1'b1;

   // Number of counts spent in a given phase of one axis.
   function automatic int unsigned phase_len(vga_phase_t phase, int unsigned act,
                                             int unsigned fp, int unsigned sync,
                                             int unsigned bp);
      case (phase)
         PH_ACTIVE: return act;
         PH_FRONT:  return fp;
         PH_SYNC:   return sync;
         default:   return bp;
      endcase
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus ACTIVE->FRONT->SYNC->BACK phase FSM.
// phase_o is the phase being entered at the coming edge, so callers can register aligned decode.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned FRONT  = VGA_H_FRONT,
   parameter int unsigned SYNC   = VGA_H_SYNC,
   parameter int unsigned BACK   = VGA_H_BACK
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       step_i,
   output logic [9:0] pos_o,
   output logic [1:0] phase_o,
   output logic       wrap_o
);

   localparam int unsigned TOTAL    = ACTIVE + FRONT + SYNC + BACK;
   localparam int unsigned FRONT_AT = phase_len(PH_ACTIVE, ACTIVE, FRONT, SYNC, BACK);
   localparam int unsigned SYNC_AT  = FRONT_AT + phase_len(PH_FRONT, ACTIVE, FRONT, SYNC, BACK);
   localparam int unsigned BACK_AT  = SYNC_AT + phase_len(PH_SYNC, ACTIVE, FRONT, SYNC, BACK);

   localparam logic [9:0] ACTIVE_LAST = 10'(FRONT_AT - 1);
   localparam logic [9:0] FRONT_LAST  = 10'(SYNC_AT - 1);
   localparam logic [9:0] SYNC_LAST   = 10'(BACK_AT - 1);
   localparam logic [9:0] LAST        = 10'(TOTAL - 1);

   if (ACTIVE == 0 || FRONT == 0 || SYNC == 0 || BACK == 0 || TOTAL > 1024) begin : g_bad_cfg
      $error("vga_axis_counter: zero-length phase or total count above 1024");
   end

   logic [9:0] count_q, count_d;
   vga_phase_t phase_q, phase_d;
   logic       wrap;

   always_comb begin
      count_d = count_q;
      phase_d = phase_q;
      wrap    = step_i && (count_q == LAST);
      if (step_i) begin
         count_d = wrap ? 10'd0 : count_q + 10'd1;
         // Each phase ends on the last count it owns; the next count opens the following phase.
         case (phase_q)
            PH_ACTIVE: if (count_q == ACTIVE_LAST) phase_d = PH_FRONT;
            PH_FRONT:  if (count_q == FRONT_LAST)  phase_d = PH_SYNC;
            PH_SYNC:   if (count_q == SYNC_LAST)   phase_d = PH_BACK;
            default:   if (wrap)                   phase_d = PH_ACTIVE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= LAST;
         phase_q <= PH_BACK;
      end else begin
         count_q <= count_d;
         phase_q <= phase_d;
      end
   end

   assign pos_o   = count_q;
   assign phase_o = phase_d;
   assign wrap_o  = wrap;

endmodule

// File: rtl/vga_timing_core.sv
// Raster timing source: registered hpos/vpos, syncs, display_on and line/frame strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 8-bit frame counter; otherwise frame_cnt is 0.
module vga_timing_core
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FRONT  = VGA_H_FRONT,
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BACK   = VGA_H_BACK,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FRONT  = VGA_V_FRONT,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BACK   = VGA_V_BACK,
   parameter bit          SYNC_NEG = VGA_SYNC_NEG
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_en,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam logic SYNC_IDLE = SYNC_NEG;

   logic [1:0] h_phase_d, v_phase_d;
   logic       h_wrap, v_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (pix_en),
      .pos_o   (hpos),
      .phase_o (h_phase_d),
      .wrap_o  (h_wrap)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v_axis (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (h_wrap),
      .pos_o   (vpos),
      .phase_o (v_phase_d),
      .wrap_o  (v_wrap)
   );

   // Decode from the phases being entered so levels and strobes line up with the new coordinates.
   logic hsync_q, vsync_q, display_on_q, line_start_q, frame_start_q;
   logic hsync_d, vsync_d, display_on_d;

   assign hsync_d      = (h_phase_d == PH_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
   assign vsync_d      = (v_phase_d == PH_SYNC) ? ~SYNC_IDLE : SYNC_IDLE;
   assign display_on_d = (h_phase_d == PH_ACTIVE) && (v_phase_d == PH_ACTIVE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync_q       <= SYNC_IDLE;
         vsync_q       <= SYNC_IDLE;
         display_on_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         line_start_q  <= h_wrap;
         frame_start_q <= v_wrap;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= 8'd0;
      end else if (v_wrap) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: default 640x480 instance plus a tiny active-high instance
// whose whole frame fits in 48 pixel clocks, both checked against an arithmetic raster model.
module tb_vga_timing_core;

   typedef struct packed {
      logic [9:0] hpos;
      logic [9:0] vpos;
      logic       hsync;
      logic       vsync;
      logic       display_on;
      logic       line_start;
      logic       frame_start;
      logic [7:0] frame_cnt;
   } obs_t;

`ifdef VGA_TIMING_FRAME_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   localparam int TH_A = 4, TH_F = 1, TH_S = 2, TH_B = 1;
   localparam int TV_A = 2, TV_F = 1, TV_S = 2, TV_B = 1;
   localparam int T_FRAME = (TH_A + TH_F + TH_S + TH_B) * (TV_A + TV_F + TV_S + TV_B);

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic pix_en = 1'b0;

   logic [9:0] b_hpos, b_vpos, t_hpos, t_vpos;
   logic       b_hsync, b_vsync, b_disp, b_line, b_frame;
   logic       t_hsync, t_vsync, t_disp, t_line, t_frame;
   logic [7:0] b_cnt, t_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int n_edges = 0;
   bit last_en = 1'b0;

   always #5 clk = ~clk;

   vga_timing_core u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .hpos        (b_hpos),
      .vpos        (b_vpos),
      .hsync       (b_hsync),
      .vsync       (b_vsync),
      .display_on  (b_disp),
      .line_start  (b_line),
      .frame_start (b_frame),
      .frame_cnt   (b_cnt)
   );

   vga_timing_core #(
      .H_ACTIVE (TH_A), .H_FRONT (TH_F), .H_SYNC (TH_S), .H_BACK (TH_B),
      .V_ACTIVE (TV_A), .V_FRONT (TV_F), .V_SYNC (TV_S), .V_BACK (TV_B),
      .SYNC_NEG (1'b0)
   ) u_tiny (
      .clk         (clk),
      .rst_n       (rst_n),
      .pix_en      (pix_en),
      .hpos        (t_hpos),
      .vpos        (t_vpos),
      .hsync       (t_hsync),
      .vsync       (t_vsync),
      .display_on  (t_disp),
      .line_start  (t_line),
      .frame_start (t_frame),
      .frame_cnt   (t_cnt)
   );

   // Enabled-edge count since reset drives the whole reference model.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_edges <= 0;
         last_en <= 1'b0;
      end else begin
         last_en <= pix_en;
         if (pix_en) n_edges <= n_edges + 1;
      end
   end

   function automatic obs_t model(int n, bit strobe, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, bit neg);
      int ht, vt, h, v;
      obs_t e;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      if (n == 0) begin
         h = ht - 1;
         v = vt - 1;
      end else begin
         h = (n - 1) % ht;
         v = ((n - 1) / ht) % vt;
      end
      e.hpos        = 10'(h);
      e.vpos        = 10'(v);
      e.hsync       = (h >= ha + hf && h < ha + hf + hs) ? ~neg : neg;
      e.vsync       = (v >= va + vf && v < va + vf + vs) ? ~neg : neg;
      e.display_on  = (h < ha) && (v < va);
      e.line_start  = strobe && (n > 0) && (h == 0);
      e.frame_start = e.line_start && (v == 0);
      e.frame_cnt   = (CNT_EN && n > 0) ? 8'((((n - 1) / (ht * vt)) + 1) % 256) : 8'd0;
      return e;
   endfunction

   function automatic obs_t exp_big();
      return model(n_edges, last_en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
   endfunction

   function automatic obs_t exp_tiny();
      return model(n_edges, last_en, TH_A, TH_F, TH_S, TH_B, TV_A, TV_F, TV_S, TV_B, 1'b0);
   endfunction

   function automatic obs_t got_big();
      return {b_hpos, b_vpos, b_hsync, b_vsync, b_disp, b_line, b_frame, b_cnt};
   endfunction

   function automatic obs_t got_tiny();
      return {t_hpos, t_vpos, t_hsync, t_vsync, t_disp, t_line, t_frame, t_cnt};
   endfunction

   task automatic test_reset();
      obs_t e;
      #1 rst_n = 1'b0;
      pix_en = 1'b0;
      repeat (3) @(negedge clk);
      e = model(0, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
      n_tests++;
      if (got_big() !== e) begin
         n_fail++;
         $display("FAIL reset_big got=%h exp=%h", got_big(), e);
      end
      e = model(0, 1'b0, TH_A, TH_F, TH_S, TH_B, TV_A, TV_F, TV_S, TV_B, 1'b0);
      n_tests++;
      if (got_tiny() !== e) begin
         n_fail++;
         $display("FAIL reset_tiny got=%h exp=%h", got_tiny(), e);
      end
      rst_n  = 1'b1;
      pix_en = 1'b1;
      @(negedge clk);
      e = '{hpos: 10'd0, vpos: 10'd0, hsync: 1'b1, vsync: 1'b1, display_on: 1'b1,
            line_start: 1'b1, frame_start: 1'b1, frame_cnt: CNT_EN ? 8'd1 : 8'd0};
      n_tests++;
      if (got_big() !== e) begin
         n_fail++;
         $display("FAIL first_cycle_big got=%h exp=%h", got_big(), e);
      end
      n_tests++;
      if (got_tiny() !== exp_tiny()) begin
         n_fail++;
         $display("FAIL first_cycle_tiny got=%h exp=%h", got_tiny(), exp_tiny());
      end
   endtask

   task automatic test_line_sweep();
      int hsync_low = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (b_vpos == 10'd0 && b_hsync == 1'b0) hsync_low++;
         n_tests++;
         if (got_big() !== exp_big()) begin
            n_fail++;
            $display("FAIL sweep_big cyc=%0d got=%h exp=%h", i, got_big(), exp_big());
         end
      end
      n_tests++;
      if (hsync_low != 96) begin
         n_fail++;
         $display("FAIL hsync_width got=%0d exp=96", hsync_low);
      end
      n_tests++;
      if ({b_line, b_hpos, b_vpos} !== {1'b1, 10'd0, 10'd1}) begin
         n_fail++;
         $display("FAIL line2_start got=%b/%0d/%0d exp=1/0/1", b_line, b_hpos, b_vpos);
      end
   endtask

   task automatic test_pix_en_toggle();
      logic prev_fs = 1'b0, prev_ls = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         n_tests++;
         if (got_big() !== exp_big()) begin
            n_fail++;
            $display("FAIL toggle_big cyc=%0d got=%h exp=%h", i, got_big(), exp_big());
         end
         n_tests++;
         if (got_tiny() !== exp_tiny()) begin
            n_fail++;
            $display("FAIL toggle_tiny cyc=%0d got=%h exp=%h", i, got_tiny(), exp_tiny());
         end
         n_tests++;
         if ((prev_fs && t_frame) || (prev_ls && b_line)) begin
            n_fail++;
            $display("FAIL strobe_double cyc=%0d got=%b%b exp=00", i, prev_fs && t_frame,
                     prev_ls && b_line);
         end
         prev_fs = t_frame;
         prev_ls = b_line;
         pix_en = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic test_frames();
      int k = 0;
      int last_i = 0;
      @(negedge clk);
      rst_n  = 1'b0;
      pix_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 257 * T_FRAME; i++) begin
         @(negedge clk);
         n_tests++;
         if (got_tiny() !== exp_tiny()) begin
            n_fail++;
            $display("FAIL frames_tiny cyc=%0d got=%h exp=%h", i, got_tiny(), exp_tiny());
         end
         if (t_frame) begin
            k++;
            n_tests++;
            if (t_cnt !== (CNT_EN ? 8'(k % 256) : 8'd0)) begin
               n_fail++;
               $display("FAIL frame_cnt frame=%0d got=%0d exp=%0d", k, t_cnt,
                        CNT_EN ? (k % 256) : 0);
            end
            if (k > 1) begin
               n_tests++;
               if (i - last_i != T_FRAME) begin
                  n_fail++;
                  $display("FAIL frame_period got=%0d exp=%0d", i - last_i, T_FRAME);
               end
            end
            last_i = i;
         end
      end
      n_tests++;
      if (k != 257) begin
         n_fail++;
         $display("FAIL frame_count got=%0d exp=257", k);
      end
   endtask

   task automatic test_mid_reset();
      obs_t e;
      @(negedge clk);
      rst_n  = 1'b0;
      pix_en = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 301; i++) begin
         @(negedge clk);
         n_tests++;
         if (got_big() !== exp_big()) begin
            n_fail++;
            $display("FAIL pre_reset_big cyc=%0d got=%h exp=%h", i, got_big(), exp_big());
         end
      end
      n_tests++;
      if (b_hpos !== 10'd300) begin
         n_fail++;
         $display("FAIL mid_line_pos got=%0d exp=300", b_hpos);
      end
      #2 rst_n = 1'b0;
      #1;
      e = model(0, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
      n_tests++;
      if (got_big() !== e) begin
         n_fail++;
         $display("FAIL async_reset_big got=%h exp=%h", got_big(), e);
      end
      e = model(0, 1'b0, TH_A, TH_F, TH_S, TH_B, TV_A, TV_F, TV_S, TV_B, 1'b0);
      n_tests++;
      if (got_tiny() !== e) begin
         n_fail++;
         $display("FAIL async_reset_tiny got=%h exp=%h", got_tiny(), e);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_tests++;
         if (got_big() !== exp_big() || got_tiny() !== exp_tiny()) begin
            n_fail++;
            $display("FAIL post_reset cyc=%0d got=%h/%h exp=%h/%h", i, got_big(), got_tiny(),
                     exp_big(), exp_tiny());
         end
      end
   endtask

   initial begin
      test_reset();
      test_line_sweep();
      test_pix_en_toggle();
      test_frames();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
